// File: rtl/bm_rel_sched.sv
// rtl/bm_rel_sched.sv - release scheduler: counter-clear walk, then round-robin release arbitration
module bm_rel_sched #(
    parameter int NUM_REQ       = 4,
    parameter int BUF_PTR_NBITS = 10,
    parameter int PORT_ID_NBITS = 3,
    parameter int CNT_NBITS     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              init_start,
    input  logic                              rel_stall,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*PORT_ID_NBITS-1:0]  req_port_id,
    input  logic [NUM_REQ*BUF_PTR_NBITS-1:0]  req_ptr,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              init_read_count_valid,
    output logic [BUF_PTR_NBITS-1:0]          init_read_count_ptr,
    output logic                              tm_rel_buf_valid,
    output logic [PORT_ID_NBITS-1:0]          tm_rel_buf_port_id,
    output logic [BUF_PTR_NBITS-1:0]          tm_rel_buf_ptr,
    output logic                              init_done,
    output logic [CNT_NBITS-1:0]              rel_cnt
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [BUF_PTR_NBITS-1:0]   walk_ptr_q, walk_ptr_d;
    logic [RR_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic                       irc_valid_q, irc_valid_d;
    logic [BUF_PTR_NBITS-1:0]   irc_ptr_q, irc_ptr_d;
    logic                       rel_valid_q, rel_valid_d;
    logic [PORT_ID_NBITS-1:0]   rel_port_q, rel_port_d;
    logic [BUF_PTR_NBITS-1:0]   rel_ptr_q, rel_ptr_d;
    logic                       init_done_q, init_done_d;
    logic [CNT_NBITS-1:0]       rel_cnt_q, rel_cnt_d;

    logic                       eligible;
    logic                       grant_found;
    logic                       xfer;
    logic [RR_W-1:0]            grant_idx;
    logic [RR_W:0]              cand_sum;
    logic [PORT_ID_NBITS-1:0]   sel_port;
    logic [BUF_PTR_NBITS-1:0]   sel_ptr;

    // Rotating priority search starting at rr_ptr; the mux is steered by the one-hot grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
            if (cand_sum >= (RR_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (RR_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand_sum[RR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[RR_W-1:0];
            end
        end
        eligible  = (state_q == ST_RUN) && !rel_stall && !init_start;
        xfer      = eligible && grant_found;
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_idx] = 1'b1;
        end
        sel_port = '0;
        sel_ptr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_port = req_port_id[i*PORT_ID_NBITS +: PORT_ID_NBITS];
                sel_ptr  = req_ptr[i*BUF_PTR_NBITS +: BUF_PTR_NBITS];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        walk_ptr_d  = walk_ptr_q;
        rr_ptr_d    = rr_ptr_q;
        irc_valid_d = 1'b0;
        irc_ptr_d   = irc_ptr_q;
        rel_valid_d = xfer;
        rel_port_d  = rel_port_q;
        rel_ptr_d   = rel_ptr_q;
        rel_cnt_d   = rel_cnt_q + {{(CNT_NBITS-1){1'b0}}, xfer};

        if (xfer) begin
            rel_port_d = sel_port;
            rel_ptr_d  = sel_ptr;
            rr_ptr_d   = (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        case (state_q)
            ST_INIT: begin
                // Leave INIT only once the last pointer has actually been presented.
                if (irc_valid_q && (irc_ptr_q == '1)) begin
                    state_d    = ST_RUN;
                    walk_ptr_d = '0;
                end else begin
                    irc_valid_d = 1'b1;
                    irc_ptr_d   = walk_ptr_q;
                    walk_ptr_d  = walk_ptr_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (init_start) begin
                    state_d    = ST_INIT;
                    walk_ptr_d = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        init_done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            walk_ptr_q  <= '0;
            rr_ptr_q    <= '0;
            irc_valid_q <= 1'b0;
            irc_ptr_q   <= '0;
            rel_valid_q <= 1'b0;
            rel_port_q  <= '0;
            rel_ptr_q   <= '0;
            init_done_q <= 1'b0;
            rel_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            walk_ptr_q  <= walk_ptr_d;
            rr_ptr_q    <= rr_ptr_d;
            irc_valid_q <= irc_valid_d;
            irc_ptr_q   <= irc_ptr_d;
            rel_valid_q <= rel_valid_d;
            rel_port_q  <= rel_port_d;
            rel_ptr_q   <= rel_ptr_d;
            init_done_q <= init_done_d;
            rel_cnt_q   <= rel_cnt_d;
        end
    end

    assign init_read_count_valid = irc_valid_q;
    assign init_read_count_ptr   = irc_ptr_q;
    assign tm_rel_buf_valid      = rel_valid_q;
    assign tm_rel_buf_port_id    = rel_port_q;
    assign tm_rel_buf_ptr        = rel_ptr_q;
    assign init_done             = init_done_q;
    assign rel_cnt               = rel_cnt_q;

endmodule

// File: tb/tb_bm_rel_sched.sv
// tb/tb_bm_rel_sched.sv - bench for bm_rel_sched: queue-based reference model plus directed scenarios
module tb_bm_rel_sched;

    localparam int NR    = 4;
    localparam int BP    = 4;
    localparam int PW    = 3;
    localparam int CW    = 8;
    localparam int NWALK = 1 << BP;

    logic               clk = 1'b0;
    logic               rst;
    logic               init_start;
    logic               rel_stall;
    logic [NR-1:0]      req_valid;
    logic [NR*PW-1:0]   req_port_id;
    logic [NR*BP-1:0]   req_ptr;
    logic [NR-1:0]      req_ready;
    logic               init_read_count_valid;
    logic [BP-1:0]      init_read_count_ptr;
    logic               tm_rel_buf_valid;
    logic [PW-1:0]      tm_rel_buf_port_id;
    logic [BP-1:0]      tm_rel_buf_ptr;
    logic               init_done;
    logic [CW-1:0]      rel_cnt;

    bm_rel_sched #(
        .NUM_REQ(NR), .BUF_PTR_NBITS(BP), .PORT_ID_NBITS(PW), .CNT_NBITS(CW)
    ) dut (
        .clk(clk), .rst(rst), .init_start(init_start), .rel_stall(rel_stall),
        .req_valid(req_valid), .req_port_id(req_port_id), .req_ptr(req_ptr),
        .req_ready(req_ready),
        .init_read_count_valid(init_read_count_valid), .init_read_count_ptr(init_read_count_ptr),
        .tm_rel_buf_valid(tm_rel_buf_valid), .tm_rel_buf_port_id(tm_rel_buf_port_id),
        .tm_rel_buf_ptr(tm_rel_buf_ptr), .init_done(init_done), .rel_cnt(rel_cnt)
    );

    always #5 clk = ~clk;

    // Model: registered outputs as they should currently appear, plus the
    // list of pointers the clear walk still owes.
    bit  m_run;
    int  m_walk[$];
    int  m_rr;
    bit  e_irc_v;
    int  e_irc_ptr;
    bit  e_rel_v;
    int  e_port;
    int  e_ptr;
    int  e_cnt;
    bit  e_done;

    int  n_checks = 0;
    int  n_err    = 0;

    logic [NR-1:0] o_ready;
    logic          o_irc_v, o_rel_v, o_done;
    logic [BP-1:0] o_irc_ptr, o_ptr;
    logic [PW-1:0] o_port;
    logic [CW-1:0] o_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_rr = 0;
        e_irc_v = 0; e_irc_ptr = 0; e_rel_v = 0; e_port = 0; e_ptr = 0; e_cnt = 0; e_done = 0;
        m_walk.delete();
        for (int i = 0; i < NWALK; i++) m_walk.push_back(i);
    endtask

    // Called at a negedge with inputs applied: compare, advance model, move to next negedge.
    task automatic step();
        logic [NR-1:0] er;
        int g;
        #1;
        g = -1;
        if (m_run && !rel_stall && !init_start) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_rr + k) % NR;
                if (g < 0 && req_valid[i]) g = i;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        check("irc_valid", 32'(init_read_count_valid), 32'(e_irc_v));
        check("irc_ptr", 32'(init_read_count_ptr), e_irc_ptr);
        check("rel_valid", 32'(tm_rel_buf_valid), 32'(e_rel_v));
        check("rel_port", 32'(tm_rel_buf_port_id), e_port);
        check("rel_ptr", 32'(tm_rel_buf_ptr), e_ptr);
        check("init_done", 32'(init_done), 32'(e_done));
        check("rel_cnt", 32'(rel_cnt), e_cnt);
        o_ready = req_ready; o_irc_v = init_read_count_valid; o_irc_ptr = init_read_count_ptr;
        o_rel_v = tm_rel_buf_valid; o_ptr = tm_rel_buf_ptr; o_port = tm_rel_buf_port_id;
        o_done = init_done; o_cnt = rel_cnt;

        if (rst) begin
            model_reset();
        end else begin
            e_rel_v = (g >= 0);
            if (g >= 0) begin
                e_port = int'(req_port_id[g*PW +: PW]);
                e_ptr  = int'(req_ptr[g*BP +: BP]);
                e_cnt  = (e_cnt + 1) % (1 << CW);
                m_rr   = (g + 1) % NR;
            end
            e_irc_v = 0;
            if (!m_run) begin
                if (m_walk.size() > 0) begin
                    e_irc_v   = 1;
                    e_irc_ptr = m_walk.pop_front();
                end else begin
                    m_run = 1;
                end
            end else if (init_start) begin
                m_run = 0;
                for (int i = 0; i < NWALK; i++) m_walk.push_back(i);
            end
            e_done = m_run;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input int port, input int ptr);
        req_port_id[i*PW +: PW] = PW'(port);
        req_ptr[i*BP +: BP]     = BP'(ptr);
    endtask

    logic [NR-1:0] rdy_h [0:22];
    logic [BP-1:0] ptr_h [0:22];
    logic          relv_h[0:22];

    initial begin
        int pulses, first_irc, first_done, k;
        bit injected, found;

        rst = 1; init_start = 0; rel_stall = 0; req_valid = '0; req_port_id = '0; req_ptr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then the clear walk and the first round-robin sweep
        step();
        rst = 0;
        for (int i = 0; i < NR; i++) set_req(i, i + 1, 10 + i);
        req_valid = 4'hF;
        pulses = 0; first_irc = -1; first_done = -1;
        for (int j = 0; j <= 22; j++) begin
            if (j == 22) req_valid = '0;
            step();
            if (o_irc_v) begin
                check("t1_walk_ptr", 32'(o_irc_ptr), pulses);
                pulses++;
                if (first_irc < 0) first_irc = j;
            end
            if (!o_done) check("t1_ready_in_init", 32'(o_ready), 0);
            if (o_done && first_done < 0) first_done = j;
            rdy_h[j] = o_ready; ptr_h[j] = o_ptr; relv_h[j] = o_rel_v;
        end
        check("t1_pulses", pulses, 16);
        check("t1_first_pulse", first_irc, 1);
        check("t1_first_done", first_done, 17);
        for (int g = 0; g < 5; g++) begin
            check("t2_grant", 32'(rdy_h[17+g]), 32'(1 << (g % 4)));
            check("t2_out_valid", 32'(relv_h[18+g]), 1);
            check("t2_out_ptr", 32'(ptr_h[18+g]), 10 + (g % 4));
        end
        check("t2_cnt", 32'(o_cnt), 5);

        // Round-robin resumes after the last grant; lone requester gets back-to-back grants
        req_valid = 4'b0100; step(); check("t3_g2", 32'(o_ready), 4);
        req_valid = 4'b1010; step(); check("t3_g3", 32'(o_ready), 8);
        req_valid = 4'b0010; step(); check("t3_g1", 32'(o_ready), 2);
        req_valid = 4'b0001;
        for (int s = 0; s < 3; s++) begin
            step(); check("t3_g0_b2b", 32'(o_ready), 1);
        end

        // Stall blocks grants; the release accepted just before still emits
        rel_stall = 1;
        for (int s = 0; s < 4; s++) begin
            step();
            check("t4_stall_ready", 32'(o_ready), 0);
            check("t4_stall_relv", 32'(o_rel_v), (s == 0) ? 1 : 0);
        end
        rel_stall = 0;
        step(); check("t4_after_stall", 32'(o_ready), 1);
        req_valid = '0;
        step(); check("t4_out_valid", 32'(o_rel_v), 1); check("t4_out_ptr", 32'(o_ptr), 10);

        // init_start beats a pending request; a second init_start mid-walk is ignored
        req_valid = 4'b0010; init_start = 1;
        step(); check("t5_no_grant", 32'(o_ready), 0);
        init_start = 0;
        k = 0; pulses = 0; injected = 0;
        while (k < 40) begin
            k++;
            if (pulses == 5 && !injected) begin
                init_start = 1; injected = 1;
            end
            step();
            init_start = 0;
            if (o_irc_v) pulses++;
            if (o_ready != '0) break;
        end
        check("t5_grant_cycle", k, 18);
        check("t5_pulses", pulses, 16);
        check("t5_grant_req1", 32'(o_ready), 2);
        req_valid = '0;

        // Reset in the middle of a walk
        init_start = 1; step(); init_start = 0;
        found = 0;
        for (int s = 0; s < 40; s++) begin
            step();
            if (o_irc_v && o_irc_ptr == 7) begin
                found = 1;
                break;
            end
        end
        check("t6_found_ptr7", 32'(found), 1);
        rst = 1; step(); rst = 0;
        step();
        check("t6_rst_irc_v", 32'(o_irc_v), 0);
        check("t6_rst_irc_ptr", 32'(o_irc_ptr), 0);
        check("t6_rst_rel_v", 32'(o_rel_v), 0);
        check("t6_rst_done", 32'(o_done), 0);
        check("t6_rst_cnt", 32'(o_cnt), 0);
        step();
        check("t6_restart_v", 32'(o_irc_v), 1);
        check("t6_restart_ptr", 32'(o_irc_ptr), 0);

        // Counter wrap
        req_valid = 4'hF; found = 0;
        for (int s = 0; s < 600; s++) begin
            step();
            if (o_cnt == {CW{1'b1}}) begin
                found = 1;
                break;
            end
        end
        check("t6_cnt_reached_max", 32'(found), 1);
        step(); check("t6_cnt_wrap", 32'(o_cnt), 0);
        req_valid = '0;

        // Randomized traffic with occasional stall, init_start and reset
        for (int c = 0; c < 3000; c++) begin
            logic [NR-1:0] prev_ready;
            prev_ready = o_ready;
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || prev_ready[i]) begin
                    req_valid[i] = ($urandom % 100) < 45;
                    set_req(i, int'($urandom % 8), int'($urandom % 16));
                end
            end
            rst        = ($urandom % 400) == 0;
            init_start = ($urandom % 60) == 0;
            rel_stall  = ($urandom % 6) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
